// File: rtl/calcn_engine.sv
// Multi-port calculator: NUM_PORTS two-cycle request ports sharing one ALU
// through a round-robin arbiter, one registered response cycle per request.

module calcn_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              gnt,
    input  logic [1:0]        alu_resp,
    input  logic [DATA_W-1:0] alu_data,
    output logic              req,
    output logic              busy,
    output logic [3:0]        cmd,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] data
);
    typedef enum logic [1:0] {IDLE, OP2, WAIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
    logic [1:0]        resp_q, resp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            resp_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
        end
    end

    // Response registers default to zero so each result lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        resp_d  = '0;
        data_d  = '0;
        case (state_q)
            IDLE: begin
                if (en && cmd_in != 4'd0) begin
                    cmd_d   = cmd_in;
                    op1_d   = data_in;
                    state_d = OP2;
                end
            end
            OP2: begin
                op2_d   = data_in;
                state_d = WAIT;
            end
            WAIT: begin
                if (gnt) begin
                    resp_d  = alu_resp;
                    data_d  = alu_data;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req  = (state_q == WAIT);
    assign busy = (state_q != IDLE);
    assign cmd  = cmd_q;
    assign op1  = op1_q;
    assign op2  = op2_q;
    assign resp = resp_q;
    assign data = data_q;
endmodule

module calcn_engine #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int SH_W      = $clog2(DATA_W)
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
    output logic [2*NUM_PORTS-1:0]        out_resp,
    output logic [DATA_W*NUM_PORTS-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          port_busy
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [1:0]                         sync_q, sync_d;
    logic [PTR_W-1:0]                   ptr_q, ptr_d, gnt_idx, cand;
    logic                               gnt_vld;
    int                                 arb_idx;
    logic [NUM_PORTS-1:0]               req, gnt;
    logic [NUM_PORTS-1:0][3:0]          p_cmd;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   p_op1, p_op2;
    logic [3:0]                         a_cmd;
    logic [DATA_W-1:0]                  a_op1, a_op2, alu_data;
    logic [1:0]                         alu_resp;
    logic [DATA_W:0]                    sum;
    logic [SH_W-1:0]                    sh;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            ptr_q  <= '0;
        end else begin
            sync_q <= sync_d;
            ptr_q  <= ptr_d;
        end
    end

    assign sync_d = {sync_q[0], 1'b1};

    // Search starts at the pointer; ptr_q < NUM_PORTS so one subtract wraps it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_idx = 0;
        cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
            cand = PTR_W'(arb_idx);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld)
            ptr_d = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    assign a_cmd = p_cmd[gnt_idx];
    assign a_op1 = p_op1[gnt_idx];
    assign a_op2 = p_op2[gnt_idx];
    assign sum   = {1'b0, a_op1} + {1'b0, a_op2};
    assign sh    = a_op2[SH_W-1:0];

    always_comb begin
        alu_resp = 2'd2;
        alu_data = '0;
        case (a_cmd)
            4'd1: if (!sum[DATA_W]) begin alu_resp = 2'd1; alu_data = sum[DATA_W-1:0]; end
            4'd2: if (a_op2 <= a_op1) begin alu_resp = 2'd1; alu_data = a_op1 - a_op2; end
            4'd5: begin alu_resp = 2'd1; alu_data = a_op1 << sh; end
            4'd6: begin alu_resp = 2'd1; alu_data = a_op1 >> sh; end
            default: ;
        endcase
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign gnt[p] = gnt_vld && (gnt_idx == PTR_W'(p));
        calcn_port #(.DATA_W(DATA_W)) u_port (
            .clk      (c_clk),
            .rst_n    (reset),
            .en       (sync_q[1]),
            .cmd_in   (req_cmd_in[p*4 +: 4]),
            .data_in  (req_data_in[p*DATA_W +: DATA_W]),
            .gnt      (gnt[p]),
            .alu_resp (alu_resp),
            .alu_data (alu_data),
            .req      (req[p]),
            .busy     (port_busy[p]),
            .cmd      (p_cmd[p]),
            .op1      (p_op1[p]),
            .op2      (p_op2[p]),
            .resp     (out_resp[p*2 +: 2]),
            .data     (out_data[p*DATA_W +: DATA_W])
        );
    end
endmodule
